sysid_reader: RTL and testbench

- Avalon-MM read master that interrogates the system-ID slave.
  - Word 0 is the system ID; word 1 is the build timestamp.
- Compares both words against build-time expected values.
- Publishes captured values and a pass/fail status to the boot/status logic (LED, host-visible status register).
- Sits on the same fabric as the sysid slave; it is the initiator end of that control_slave interface.

---
 rtl/sysid_reader_pkg.sv | 21 ++
 rtl/sysid_reader_if.sv | 27 ++
 rtl/sysid_read_unit.sv | 67 ++++++
 rtl/sysid_reader.sv | 189 ++++++++++++++++++
 tb/tb_sysid_reader.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/sysid_reader_pkg.sv
// sysid_reader_pkg: shared FSM state type, word addresses and counter sizing for the sysid reader
package sysid_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        LAT_ID,
        RD_TS,
        LAT_TS,
        DONE
    } state_t;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sysid_reader_if.sv
// sysid_reader_if: Avalon-MM read channel between the sysid reader (master) and the sysid slave
//   avm_address     : word address, master to slave
//   avm_read        : read request, master to slave
//   avm_waitrequest : stall, slave to master
//   avm_readdata    : read data, slave to master
interface sysid_reader_if;

    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );

endinterface

// File: rtl/sysid_read_unit.sv
// sysid_read_unit: single-word Avalon-MM read with waitrequest, fixed read latency and stall timeout
//   clock, reset : clock and asynchronous active-high reset
//   go           : one-cycle pulse launching a read of word addr (may coincide with the previous accept)
//   addr         : word address latched on go
//   avm          : Avalon-MM master port
//   rdata        : slave read data, meaningful when valid=1
//   accept       : read accepted this cycle (avm_read && !avm_waitrequest)
//   valid        : read data is on rdata this cycle
//   timeout      : read abandoned after TIMEOUT_CYCLES stalled cycles
module sysid_read_unit
    import sysid_reader_pkg::*;
#(
    parameter int READ_LATENCY   = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  go,
    input  logic                  addr,
    sysid_reader_if.master        avm,
    output logic [31:0]           rdata,
    output logic                  accept,
    output logic                  valid,
    output logic                  timeout
);

    localparam int LW = cnt_width(READ_LATENCY);
    localparam int SW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [LW-1:0] LAT_INIT   = LW'(READ_LATENCY);
    localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT_CYCLES - 1);

    logic          rd_q, rd_d;
    logic          addr_q, addr_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [SW-1:0] stall_q, stall_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_q    <= 1'b0;
            addr_q  <= 1'b0;
            lat_q   <= '0;
            stall_q <= '0;
        end else begin
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            lat_q   <= lat_d;
            stall_q <= stall_d;
        end
    end

    assign avm.avm_read    = rd_q;
    assign avm.avm_address = rd_q & addr_q;
    assign rdata           = avm.avm_readdata;

    // The stall on the cycle the counter would reach TIMEOUT_CYCLES aborts the read,
    // unless waitrequest drops that same cycle, in which case the accept wins.
    always_comb begin
        accept  = rd_q && !avm.avm_waitrequest;
        timeout = rd_q && avm.avm_waitrequest && (stall_q == STALL_LAST);
        valid   = (READ_LATENCY == 0) ? accept : (lat_q == LW'(1));
        rd_d    = go || (rd_q && !accept && !timeout);
        addr_d  = go ? addr : addr_q;
        stall_d = (go || !rd_q || accept || timeout) ? '0 : stall_q + 1'b1;
        lat_d   = (accept && READ_LATENCY != 0) ? LAT_INIT : (lat_q != '0) ? lat_q - 1'b1 : lat_q;
    end

endmodule

// File: rtl/sysid_reader.sv
// sysid_reader: Avalon-MM read master that fetches the system ID (word 0) and build timestamp (word 1) and checks them
//   clock, reset           : clock and asynchronous active-high reset
//   start                  : one-cycle pulse, begins a check from idle or done
//   avm                    : Avalon-MM master port to the sysid slave
//   id_value               : captured word 0
//   timestamp_value        : captured word 1
//   busy                   : check in progress
//   done                   : check finished, held until the next start
//   match                  : both words equal their expected values (valid with done)
//   error_timeout          : a read was stalled for TIMEOUT_CYCLES (valid with done)
//   mismatch_sticky        : any failing check since reset (SYSID_READER_PERIODIC_EN only)
// Build option SYSID_READER_PERIODIC_EN re-runs the check every PERIOD_CYCLES spent in DONE.
module sysid_reader
    import sysid_reader_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1605985459,
    parameter int          READ_LATENCY       = 0,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter int          AUTO_START         = 1
`ifdef SYSID_READER_PERIODIC_EN
    ,
    parameter int          PERIOD_CYCLES      = 1000000
`endif
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    sysid_reader_if.master avm,
    output logic [31:0]    id_value,
    output logic [31:0]    timestamp_value,
    output logic           busy,
    output logic           done,
    output logic           match,
    output logic           error_timeout
`ifdef SYSID_READER_PERIODIC_EN
    ,
    output logic           mismatch_sticky
`endif
);

    state_t      state_q, state_d;
    logic [31:0] id_q, id_d, ts_q, ts_d;
    logic        done_q, done_d;
    logic        match_q, match_d;
    logic        err_q, err_d;
    logic        first_q;
    logic        go, addr;
    logic        acc, vld, tmo;
    logic [31:0] rdata;

`ifdef SYSID_READER_PERIODIC_EN
    localparam int PW = cnt_width(PERIOD_CYCLES);
    localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYCLES - 1);
    logic [PW-1:0] per_q, per_d;
    logic          sticky_q, sticky_d;
`endif

    sysid_read_unit #(
        .READ_LATENCY  (READ_LATENCY),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_read (
        .clock  (clock),
        .reset  (reset),
        .go     (go),
        .addr   (addr),
        .avm    (avm),
        .rdata  (rdata),
        .accept (acc),
        .valid  (vld),
        .timeout(tmo)
    );

    // first_q marks the first cycle after reset release for the automatic check.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            id_q     <= '0;
            ts_q     <= '0;
            done_q   <= 1'b0;
            match_q  <= 1'b0;
            err_q    <= 1'b0;
            first_q  <= 1'b1;
`ifdef SYSID_READER_PERIODIC_EN
            per_q    <= '0;
            sticky_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            ts_q     <= ts_d;
            done_q   <= done_d;
            match_q  <= match_d;
            err_q    <= err_d;
            first_q  <= 1'b0;
`ifdef SYSID_READER_PERIODIC_EN
            per_q    <= per_d;
            sticky_q <= sticky_d;
`endif
        end
    end

    // go fires on every entry to RD_ID/RD_TS; with zero latency the second read is
    // launched on the accept cycle of the first so the bus never idles between them.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ts_d    = ts_q;
        done_d  = done_q;
        match_d = match_q;
        err_d   = err_q;
        go      = 1'b0;
        addr    = ADDR_ID;
`ifdef SYSID_READER_PERIODIC_EN
        per_d   = '0;
`endif
        case (state_q)
            IDLE: begin
                if (start || (AUTO_START != 0 && first_q)) begin
                    state_d = RD_ID;
                    go      = 1'b1;
                end
            end
            RD_ID, LAT_ID: begin
                if (tmo) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    match_d = 1'b0;
                    err_d   = 1'b1;
                end else if (vld) begin
                    id_d    = rdata;
                    state_d = RD_TS;
                    go      = 1'b1;
                    addr    = ADDR_TS;
                end else if (acc) begin
                    state_d = LAT_ID;
                end
            end
            RD_TS, LAT_TS: begin
                if (tmo) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    match_d = 1'b0;
                    err_d   = 1'b1;
                end else if (vld) begin
                    ts_d    = rdata;
                    state_d = DONE;
                    done_d  = 1'b1;
                    match_d = (id_q == EXPECTED_ID) && (rdata == EXPECTED_TIMESTAMP);
                    err_d   = 1'b0;
                end else if (acc) begin
                    state_d = LAT_TS;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = RD_ID;
                    go      = 1'b1;
                    done_d  = 1'b0;
                    match_d = 1'b0;
                    err_d   = 1'b0;
                end
`ifdef SYSID_READER_PERIODIC_EN
                else if (per_q == PER_LAST) begin
                    state_d = RD_ID;
                    go      = 1'b1;
                end else begin
                    per_d = per_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
`ifdef SYSID_READER_PERIODIC_EN
        sticky_d = sticky_q | (state_d == DONE && state_q != DONE && !match_d);
`endif
    end

    assign id_value        = id_q;
    assign timestamp_value = ts_q;
    assign busy            = state_q != IDLE && state_q != DONE;
    assign done            = done_q;
    assign match           = match_q;
    assign error_timeout   = err_q;
`ifdef SYSID_READER_PERIODIC_EN
    assign mismatch_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_sysid_reader.sv
// tb_sysid_reader: randomized self-checking bench for sysid_reader with zero-latency and two-cycle-latency slaves
module tb_sysid_reader;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'd1605985459;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start0 = 1'b0;
    logic start2 = 1'b0;
    always #5 clock = ~clock;

    sysid_reader_if bus0 ();
    sysid_reader_if bus2 ();

    logic [31:0] id0_v, ts0_v, id2_v, ts2_v;
    logic busy0, done0, match0, err0;
    logic busy2, done2, match2, err2;
`ifdef SYSID_READER_PERIODIC_EN
    logic sticky0, sticky2;
`endif

    sysid_reader #(.READ_LATENCY(0), .TIMEOUT_CYCLES(255), .AUTO_START(1)) u_dut0 (
        .clock(clock), .reset(reset), .start(start0), .avm(bus0),
        .id_value(id0_v), .timestamp_value(ts0_v), .busy(busy0), .done(done0),
        .match(match0), .error_timeout(err0)
`ifdef SYSID_READER_PERIODIC_EN
        , .mismatch_sticky(sticky0)
`endif
    );

    sysid_reader #(.READ_LATENCY(2), .TIMEOUT_CYCLES(255), .AUTO_START(0)) u_dut2 (
        .clock(clock), .reset(reset), .start(start2), .avm(bus2),
        .id_value(id2_v), .timestamp_value(ts2_v), .busy(busy2), .done(done2),
        .match(match2), .error_timeout(err2)
`ifdef SYSID_READER_PERIODIC_EN
        , .mismatch_sticky(sticky2)
`endif
    );

    // Slave models: each read is stalled ws cycles; slave 2 presents data two cycles after accept, junk otherwise.
    int ws0 = 0, ws2 = 0, wcnt0 = 0, wcnt2 = 0;
    logic [31:0] sid0 = EXP_ID, sts0 = EXP_TS, sid2 = EXP_ID, sts2 = EXP_TS, junk = 32'h0;
    logic p1 = 1'b0, p2 = 1'b0, a1 = 1'b0, a2 = 1'b0;

    assign bus0.avm_waitrequest = bus0.avm_read && (wcnt0 < ws0);
    assign bus0.avm_readdata    = bus0.avm_address ? sts0 : sid0;
    assign bus2.avm_waitrequest = bus2.avm_read && (wcnt2 < ws2);
    assign bus2.avm_readdata    = p2 ? (a2 ? sts2 : sid2) : junk;

    always @(posedge clock) begin
        wcnt0 <= (bus0.avm_read && bus0.avm_waitrequest) ? wcnt0 + 1 : 0;
        wcnt2 <= (bus2.avm_read && bus2.avm_waitrequest) ? wcnt2 + 1 : 0;
        p1    <= bus2.avm_read && !bus2.avm_waitrequest;
        a1    <= bus2.avm_address;
        p2    <= p1;
        a2    <= a1;
        junk  <= $urandom;
    end

    // Bus monitor: accepted-read counts and protocol violations (request not held during stall, address without read).
    int acc0 = 0, acc2 = 0, viol = 0;
    logic pr0 = 1'b0, pw0 = 1'b0, pa0 = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            pr0 <= 1'b0;
        end else begin
            viol <= viol + int'(pr0 && pw0 && (!bus0.avm_read || bus0.avm_address != pa0))
                         + int'(!bus0.avm_read && bus0.avm_address)
                         + int'(!bus2.avm_read && bus2.avm_address);
            acc0 <= acc0 + int'(bus0.avm_read && !bus0.avm_waitrequest);
            acc2 <= acc2 + int'(bus2.avm_read && !bus2.avm_waitrequest);
            pr0  <= bus0.avm_read;
            pw0  <= bus0.avm_waitrequest;
            pa0  <= bus0.avm_address;
        end
    end

    int checks = 0, passed = 0;

    task automatic wait0(input int limit, output int b);
        b = 0;
        for (int i = 0; i < limit; i++) begin
            if (busy0) b++;
            if (done0) break;
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if ({busy0, done0, match0, err0, bus0.avm_read, bus0.avm_address} !== 6'b0)
            $display("FAIL reset_ctrl0: got %b want 000000", {busy0, done0, match0, err0, bus0.avm_read, bus0.avm_address}); else passed++;
        checks++; if (id0_v !== 32'h0 || ts0_v !== 32'h0)
            $display("FAIL reset_data0: got %h/%h want 0/0", id0_v, ts0_v); else passed++;
        checks++; if ({busy2, done2, match2, err2, bus2.avm_read, bus2.avm_address} !== 6'b0 || id2_v !== 32'h0 || ts2_v !== 32'h0)
            $display("FAIL reset_dut2: got %b %h %h want all zero", {busy2, done2, match2, err2, bus2.avm_read}, id2_v, ts2_v); else passed++;
    endtask

    task automatic test_auto_start();
        int b, base0, base2;
        base0 = acc0; base2 = acc2;
        reset = 1'b0; start0 = 1'b1;
        @(negedge clock); start0 = 1'b0;
        wait0(50, b);
        checks++; if (done0 !== 1'b1) $display("FAIL auto_done: got %b want 1", done0); else passed++;
        checks++; if (match0 !== 1'b1) $display("FAIL auto_match: got %b want 1", match0); else passed++;
        checks++; if (err0 !== 1'b0) $display("FAIL auto_err: got %b want 0", err0); else passed++;
        checks++; if (b !== 2) $display("FAIL auto_busy_cycles: got %0d want 2", b); else passed++;
        checks++; if (id0_v !== EXP_ID) $display("FAIL auto_id: got %h want %h", id0_v, EXP_ID); else passed++;
        checks++; if (ts0_v !== EXP_TS) $display("FAIL auto_ts: got %0d want %0d", ts0_v, EXP_TS); else passed++;
        checks++; if (acc0 - base0 !== 2) $display("FAIL auto_single_check: got %0d reads want 2", acc0 - base0); else passed++;
        checks++; if (busy2 !== 1'b0 || done2 !== 1'b0 || acc2 !== base2)
            $display("FAIL no_auto_dut2: got busy %b done %b reads %0d want 0 0 0", busy2, done2, acc2 - base2); else passed++;
    endtask

    task automatic test_compare();
        for (int n = 0; n < 8; n++) begin
            int b, base, w;
            logic [31:0] wid, wts;
            wid = (n < 2 || $urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
            wts = (n == 0) ? EXP_TS + 32'd1 : (n == 1 || $urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
            w   = (n == 0) ? 0 : (n == 1) ? 10 : int'($urandom_range(0, 4));
            sid0 = wid; sts0 = wts; ws0 = w; base = acc0;
            start0 = 1'b1;
            @(negedge clock); start0 = 1'b0;
            checks++; if (done0 !== 1'b0 || busy0 !== 1'b1)
                $display("FAIL cmp%0d_restart: got done %b busy %b want 0 1", n, done0, busy0); else passed++;
            wait0(100, b);
            checks++; if (done0 !== 1'b1) $display("FAIL cmp%0d_done: got %b want 1", n, done0); else passed++;
            checks++; if (match0 !== (wid == EXP_ID && wts == EXP_TS))
                $display("FAIL cmp%0d_match: got %b want %b", n, match0, wid == EXP_ID && wts == EXP_TS); else passed++;
            checks++; if (err0 !== 1'b0) $display("FAIL cmp%0d_err: got %b want 0", n, err0); else passed++;
            checks++; if (b !== 2 + 2 * w) $display("FAIL cmp%0d_busy_cycles: got %0d want %0d", n, b, 2 + 2 * w); else passed++;
            checks++; if (id0_v !== wid || ts0_v !== wts)
                $display("FAIL cmp%0d_data: got %h/%h want %h/%h", n, id0_v, ts0_v, wid, wts); else passed++;
            checks++; if (acc0 - base !== 2) $display("FAIL cmp%0d_reads: got %0d want 2", n, acc0 - base); else passed++;
        end
        checks++; if (viol !== 0) $display("FAIL bus_protocol: got %0d violations want 0", viol); else passed++;
    endtask

    task automatic test_timeout();
        int hi = 0, last = 0, first_done = 0, b;
        logic [31:0] oid, ots;
        oid = sid0; ots = sts0;
        sid0 = ~oid; sts0 = ~ots; ws0 = 1000000;
        start0 = 1'b1;
        @(negedge clock); start0 = 1'b0;
        for (int k = 1; k <= 270; k++) begin
            if (bus0.avm_read) begin hi++; last = k; end
            if (done0 && first_done == 0) first_done = k;
            @(negedge clock);
        end
        checks++; if (hi !== 255 || last !== 255)
            $display("FAIL to_read_cycles: got %0d high, last %0d want 255, 255", hi, last); else passed++;
        checks++; if (first_done !== 256) $display("FAIL to_done_cycle: got %0d want 256", first_done); else passed++;
        checks++; if (done0 !== 1'b1 || err0 !== 1'b1 || match0 !== 1'b0)
            $display("FAIL to_status: got done %b err %b match %b want 1 1 0", done0, err0, match0); else passed++;
        checks++; if (id0_v !== oid || ts0_v !== ots)
            $display("FAIL to_data_kept: got %h/%h want %h/%h", id0_v, ts0_v, oid, ots); else passed++;
        sid0 = EXP_ID; sts0 = EXP_TS; ws0 = 254;
        start0 = 1'b1;
        @(negedge clock); start0 = 1'b0;
        wait0(600, b);
        checks++; if (done0 !== 1'b1 || err0 !== 1'b0 || match0 !== 1'b1)
            $display("FAIL to_edge_status: got done %b err %b match %b want 1 0 1", done0, err0, match0); else passed++;
        checks++; if (b !== 510) $display("FAIL to_edge_busy_cycles: got %0d want 510", b); else passed++;
    endtask

    task automatic test_latency();
        for (int n = 0; n < 4; n++) begin
            int b = 0, base, w;
            logic [31:0] wid, wts;
            wid = (n == 0 || $urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
            wts = (n == 0 || $urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
            w   = (n == 0) ? 0 : int'($urandom_range(0, 3));
            sid2 = wid; sts2 = wts; ws2 = w; base = acc2;
            start2 = 1'b1;
            @(negedge clock);
            for (int i = 0; i < 60; i++) begin
                if (busy2) b++;
                start2 = (i == 2);
                if (done2) break;
                @(negedge clock);
            end
            start2 = 1'b0;
            checks++; if (done2 !== 1'b1 || err2 !== 1'b0)
                $display("FAIL lat%0d_status: got done %b err %b want 1 0", n, done2, err2); else passed++;
            checks++; if (match2 !== (wid == EXP_ID && wts == EXP_TS))
                $display("FAIL lat%0d_match: got %b want %b", n, match2, wid == EXP_ID && wts == EXP_TS); else passed++;
            checks++; if (id2_v !== wid || ts2_v !== wts)
                $display("FAIL lat%0d_data: got %h/%h want %h/%h", n, id2_v, ts2_v, wid, wts); else passed++;
            checks++; if (b !== 2 * (w + 3)) $display("FAIL lat%0d_busy_cycles: got %0d want %0d", n, b, 2 * (w + 3)); else passed++;
            checks++; if (acc2 - base !== 2) $display("FAIL lat%0d_reads: got %0d want 2", n, acc2 - base); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        int b;
        bit seen = 1'b0;
        sid0 = EXP_ID; sts0 = EXP_TS; ws0 = 5;
        start0 = 1'b1;
        @(negedge clock); start0 = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus0.avm_read && bus0.avm_address) seen = 1'b1;
            else @(negedge clock);
        end
        checks++; if (!seen) $display("FAIL mid_reach_ts_read: got no timestamp read want one"); else passed++;
        #2 reset = 1'b1;
        #1;
        checks++; if ({bus0.avm_read, bus0.avm_address, busy0, done0, match0, err0} !== 6'b0 || id0_v !== 32'h0 || ts0_v !== 32'h0)
            $display("FAIL mid_reset_outputs: got %b %h %h want all zero", {bus0.avm_read, bus0.avm_address, busy0, done0, match0, err0}, id0_v, ts0_v); else passed++;
        @(negedge clock); reset = 1'b0;
        @(negedge clock);
        wait0(100, b);
        checks++; if (done0 !== 1'b1 || match0 !== 1'b1 || err0 !== 1'b0)
            $display("FAIL mid_recheck_status: got done %b match %b err %b want 1 1 0", done0, match0, err0); else passed++;
        checks++; if (b !== 12) $display("FAIL mid_recheck_busy_cycles: got %0d want 12", b); else passed++;
        checks++; if (id0_v !== EXP_ID || ts0_v !== EXP_TS)
            $display("FAIL mid_recheck_data: got %h/%h want %h/%h", id0_v, ts0_v, EXP_ID, EXP_TS); else passed++;
    endtask

    initial begin
        test_reset();
        test_auto_start();
        test_compare();
        test_timeout();
        test_latency();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
